// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and step-kind type for the prescaled counter
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_WIDTH   = 24;
  localparam int DEF_PRESC_W = 16;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    STEP = 2'd1,
    LOAD = 2'd2,
    CLR  = 2'd3
  } step_kind_t;

  // Resolves what the counter does this cycle: clear beats load beats step.
  function automatic step_kind_t step_kind(input logic clr, input logic load, input logic tick);
    if (clr)
      return CLR;
    else if (load)
      return LOAD;
    else if (tick)
      return STEP;
    else
      return NONE;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable-gated prescaler, tick once every lim+1 enabled cycles
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] lim,
  output logic               tick
);

  logic [PRESC_W-1:0] presc;

  // Comparing with >= lets a lowered limit fire on the next enabled cycle
  // instead of waiting for the prescaler to wrap around.
  assign tick = en && (presc >= lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (clr || tick)
      presc <= '0;
    else if (en)
      presc <= presc + PRESC_W'(1);
  end

endmodule

// File: rtl/prescaled_counter.sv
// rtl/prescaled_counter.sv - prescaled up/down counter with wrap/saturate and terminal-count pulse
// Optional compare flag enabled by defining PRESCALED_COUNTER_CMP_EN.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] presc_lim,
  input  logic               dir,
  input  logic               sat,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic [WIDTH-1:0]   cnt,
  output logic               tick,
  output logic               tc,
  output logic               cmp_match
);

  logic             tick_i;
  step_kind_t       kind;
  logic             at_term;
  logic [WIDTH-1:0] cnt_nxt;

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .lim   (presc_lim),
    .tick  (tick_i)
  );

  assign tick = tick_i;

  always_comb begin
    kind    = step_kind(clr, load, tick_i);
    at_term = (dir == DIR_UP) ? (cnt == '1) : (cnt == '0);
    cnt_nxt = cnt;
    unique case (kind)
      CLR:     cnt_nxt = '0;
      LOAD:    cnt_nxt = load_val;
      STEP: begin
        // Saturating mode holds at the terminal value; otherwise the
        // modulo arithmetic gives the wrap for free.
        if (!(at_term && sat))
          cnt_nxt = (dir == DIR_UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
      end
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tc  <= (kind == STEP) && at_term;
    end
  end

`ifdef PRESCALED_COUNTER_CMP_EN
  // Compare against the next value so the flag lines up with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cmp_match <= 1'b0;
    else
      cmp_match <= (cnt_nxt == cmp_val);
  end
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^cmp_val;
  assign cmp_match      = 1'b0;
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// tb/tb_prescaled_counter.sv - scoreboard bench for prescaled_counter (WIDTH=8)
module tb_prescaled_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] presc_lim;
  logic       dir;
  logic       sat;
  logic [7:0] cmp_val;
  logic [7:0] cnt;
  logic       tick;
  logic       tc;
  logic       cmp_match;

  always #5 clk = ~clk;

  prescaled_counter #(
    .WIDTH   (8),
    .PRESC_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .presc_lim (presc_lim),
    .dir       (dir),
    .sat       (sat),
    .cmp_val   (cmp_val),
    .cnt       (cnt),
    .tick      (tick),
    .tc        (tc),
    .cmp_match (cmp_match)
  );

  typedef struct {
    int         due;
    string      name;
    logic [7:0] c;
    logic       t;
    logic       m;
    logic       k;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_cmp(input logic [7:0] c);
`ifdef PRESCALED_COUNTER_CMP_EN
    return (c == 8'd5);
`else
    return 1'b0;
`endif
  endfunction

  // Expected visible state for the current cycle (sampled on the falling edge).
  task automatic expect_state(input string name, input logic [7:0] c, input logic t, input logic k);
    exp_t e;
    e.due  = cyc;
    e.name = name;
    e.c    = c;
    e.t    = t;
    e.m    = exp_cmp(c);
    e.k    = k;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.due != cyc || cnt !== e.c || tc !== e.t || cmp_match !== e.m || tick !== e.k) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d got cnt=%h tc=%b cmp=%b tick=%b want cnt=%h tc=%b cmp=%b tick=%b",
                   e.name, cyc, e.due, cnt, tc, cmp_match, tick, e.c, e.t, e.m, e.k);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got cyc=%0d want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    presc_lim = 8'd3; dir = 1'b1; sat = 1'b0; cmp_val = 8'd5;
    step();
    step();
    expect_state("reset", 8'h00, 1'b0, 1'b0);
    step();

    // Free-run count, tick every 4th enabled cycle
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      expect_state("count", 8'(i / 4), 1'b0, (i % 4) == 3);
      step();
    end

    // Load 0xFE and wrap upward with presc_lim=0
    load = 1'b1; load_val = 8'hFE; presc_lim = 8'd0;
    expect_state("cnt40", 8'd10, 1'b0, 1'b1); step();
    load = 1'b0;
    expect_state("ld_fe", 8'hFE, 1'b0, 1'b1); step();
    expect_state("up_ff", 8'hFF, 1'b0, 1'b1); step();
    expect_state("wrap_00", 8'h00, 1'b1, 1'b1); step();
    load = 1'b1; sat = 1'b1;
    expect_state("up_01", 8'h01, 1'b0, 1'b1); step();

    // Saturate at 0xFF
    load = 1'b0;
    expect_state("sat_ld", 8'hFE, 1'b0, 1'b1); step();
    expect_state("sat_ff", 8'hFF, 1'b0, 1'b1); step();
    expect_state("sat_hold1", 8'hFF, 1'b1, 1'b1); step();
    expect_state("sat_hold2", 8'hFF, 1'b1, 1'b1); step();
    clr = 1'b1;
    expect_state("sat_hold3", 8'hFF, 1'b1, 1'b1); step();

    // Down wrap from zero, then clr+load together
    clr = 1'b0; dir = 1'b0; sat = 1'b0;
    expect_state("clr_zero", 8'h00, 1'b0, 1'b1); step();
    clr = 1'b1; load = 1'b1; load_val = 8'h33;
    expect_state("down_wrap", 8'hFF, 1'b1, 1'b1); step();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    expect_state("clr_load", 8'h00, 1'b0, 1'b0); step();
    expect_state("en_hold", 8'h00, 1'b0, 1'b0); step();

    // Reset mid-period at presc=2, cnt=0x55
    load = 1'b1; load_val = 8'h55; presc_lim = 8'd3;
    expect_state("en_hold2", 8'h00, 1'b0, 1'b0); step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    expect_state("ld_55", 8'h55, 1'b0, 1'b0); step();
    expect_state("presc1", 8'h55, 1'b0, 1'b0); step();
    #1;
    rst_n = 1'b0;
    expect_state("async_rst", 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_state("rst_period", 8'h00, 1'b0, i == 3);
      step();
    end
    expect_state("rst_step", 8'h01, 1'b0, 1'b0);
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 24: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter PRESC_W, default 16: prescaler width in bits, legal range 1..24.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1: enables the prescaler; when low, all state holds except clr and load.
REQ-006 SHALL have port clr, input, 1: synchronous clear of counter and prescaler.
REQ-007 SHALL have port load, input, 1: synchronous load of load_val into the counter.
REQ-008 SHALL have port load_val, input, WIDTH: value taken by load.
REQ-009 SHALL have port presc_lim, input, PRESC_W: step period is presc_lim+1 enabled cycles.
REQ-010 SHALL have port dir, input, 1: 1 = count up, 0 = count down.
REQ-011 SHALL have port sat, input, 1: 1 = saturate at terminal value, 0 = wrap.
REQ-012 SHALL have port cmp_val, input, WIDTH: compare value.
REQ-013 SHALL have port cnt, output, WIDTH: registered counter value.
REQ-014 SHALL have port tick, output, 1: combinational step strobe, en && (presc >= presc_lim).
REQ-015 SHALL have port tc, output, 1: registered terminal-count pulse.
REQ-016 SHALL have port cmp_match, output, 1: registered compare flag.

Function
REQ-017 SHALL use an internal PRESC_W-bit prescaler: on tick it returns to 0; otherwise, when en=1, it increments by 1.
REQ-018 SHALL, with presc_lim=0 and en=1, assert tick on every cycle.
REQ-019 SHALL treat presc >= presc_lim as a tick, so lowering presc_lim mid-period causes a tick on the next enabled cycle with no long wrap.
REQ-020 SHALL apply priority clr > load > step in any cycle.
REQ-021 SHALL, on clr, set cnt=0 and presc=0 at the next edge, and SHALL suppress tc for that cycle.
REQ-022 SHALL, on load (without clr), set cnt=load_val at the next edge; the prescaler is unaffected and tc is suppressed.
REQ-023 SHALL, on tick with neither clr nor load, step cnt by +1 (dir=1) or -1 (dir=0) at the same edge.
REQ-024 SHALL define the terminal value as all-ones for up and zero for down.
REQ-025 SHALL, on a step from the terminal value with sat=0, wrap modulo 2^WIDTH (max->0 or 0->max).
REQ-026 SHALL, on a step from the terminal value with sat=1, hold cnt.
REQ-027 SHALL assert tc for exactly one cycle after any step taken from the terminal value, in either sat mode.
REQ-028 SHALL reflect dir and sat changes on the next step, with no pipeline delay.

Reset
REQ-029 SHALL, while rst_n=0, force cnt=0, presc=0, tc=0 and cmp_match=0 asynchronously.
REQ-030 SHALL, on rst_n deassertion, produce its first possible tick after presc_lim+1 enabled cycles; reset mid-period discards the partial period.

Configuration
REQ-031 SHALL gate the compare feature with macro PRESCALED_COUNTER_CMP_EN.
REQ-032 SHALL, with PRESCALED_COUNTER_CMP_EN defined, register cmp_match = (next cnt == cmp_val) so that it aligns with cnt.
REQ-033 SHALL, without PRESCALED_COUNTER_CMP_EN, keep the cmp_val and cmp_match ports, tie cmp_match to 0 and ignore cmp_val.

Structure
REQ-034 SHALL place in shared package counter_pkg: DIR_UP/DIR_DOWN constants, default WIDTH/PRESC_W constants, and a step-kind typedef (NONE, STEP, LOAD, CLR).
REQ-035 SHALL implement the prescaler as sub-module counter_prescaler (ports clk, rst_n, en, clr, lim, tick).

Verification
REQ-036 SHALL cover this scenario: WIDTH=8, presc_lim=3, dir=1, en=1 held for 40 cycles from reset -> cnt=10, tick every 4th cycle.
REQ-037 SHALL cover this scenario: WIDTH=8, load 0xFE, presc_lim=0, dir=1, sat=0 -> cnt goes 0xFF, 0x00, 0x01, with tc high only the cycle after 0xFF->0x00.
REQ-038 SHALL cover this scenario: same setup with sat=1 -> cnt stays 0xFF, with tc pulsing after each attempted step.
REQ-039 SHALL cover this scenario: dir=0 from cnt=0, sat=0 -> cnt=0xFF and tc=1; then clr and load asserted together -> cnt=0, with no tc.
REQ-040 SHALL cover this scenario: rst_n pulled low mid-period with presc=2, cnt=0x55 -> cnt=0 immediately with no clock edge, and the first tick comes presc_lim+1 cycles after release.
REQ-041 SHALL cover this scenario: with PRESCALED_COUNTER_CMP_EN, cmp_val=5 -> cmp_match high in the same cycle cnt=5; without the macro -> cmp_match stays 0.
